// File: rtl/blocpu_run_sequencer.sv
// blocpu_run_sequencer
// Host-facing run controller for the blocpu core. Streams a program from the
// host into instruction memory while the core is held in reset. It then holds
// reset for BOOT_CYCLES more cycles, pulses core_run, and watches the run with
// a cycle watchdog. Finally it captures the exit code and the last debug output.
//
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   host_start           begin a load (honoured in IDLE or DONE only)
//   host_run_limit       watchdog limit, latched on an accepted host_start (0 = off)
//   host_word/_valid/_last, host_word_ready   program word stream
//   imem_write/_address/_data                 registered instruction memory write
//   core_reset, core_run                      core control
//   core_running, core_exit_code, core_output, core_output_strobe   core status
//   busy, done, timed_out, exit_code, last_output, cycles           run status
//   debug_state          current FSM state encoding
//
// Handshake: a word is transferred on every rising clock edge where
// host_word_valid and host_word_ready are both 1. host_word_ready depends only
// on the registered state, never on host_word_valid. The host must hold
// host_word and host_last stable while host_word_valid is high and the word
// has not yet been taken.
module blocpu_run_sequencer #(
  parameter int CPU_WIDTH         = 8,
  parameter int INSTRUCTION_WIDTH = CPU_WIDTH + 4,
  parameter int WATCHDOG_WIDTH    = 16,
  parameter int BOOT_CYCLES       = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         host_start,
  input  logic [WATCHDOG_WIDTH-1:0]    host_run_limit,
  input  logic [INSTRUCTION_WIDTH-1:0] host_word,
  input  logic                         host_word_valid,
  input  logic                         host_last,
  output logic                         host_word_ready,
  output logic                         imem_write,
  output logic [CPU_WIDTH-1:0]         imem_address,
  output logic [INSTRUCTION_WIDTH-1:0] imem_data,
  output logic                         core_reset,
  output logic                         core_run,
  input  logic                         core_running,
  input  logic [CPU_WIDTH-1:0]         core_exit_code,
  input  logic [CPU_WIDTH-1:0]         core_output,
  input  logic                         core_output_strobe,
  output logic                         busy,
  output logic                         done,
  output logic                         timed_out,
  output logic [CPU_WIDTH-1:0]         exit_code,
  output logic [CPU_WIDTH-1:0]         last_output,
  output logic [WATCHDOG_WIDTH-1:0]    cycles,
  output logic [2:0]                   debug_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_BOOT = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

  state_t                      state;
  state_t                      next_state;
  logic [CPU_WIDTH-1:0]        load_ptr;
  logic [WATCHDOG_WIDTH-1:0]   run_limit;
  logic [BOOT_W-1:0]           boot_cnt;
  // High only during the first RUN cycle; core_running is not yet meaningful then.
  logic                        run_first;

  logic start_ok;
  logic word_accept;
  logic ptr_at_end;
  logic halt_exit;
  logic wd_exit;

  assign start_ok    = host_start && ((state == S_IDLE) || (state == S_DONE));
  assign word_accept = (state == S_LOAD) && host_word_valid;
  assign ptr_at_end  = (load_ptr == '1);
  assign halt_exit   = (state == S_RUN) && !run_first && !core_running;
  // Halt takes priority over the watchdog where both are true.
  assign wd_exit     = (state == S_RUN) && (run_limit != '0) && (cycles == run_limit);

  // State decode
  assign host_word_ready = (state == S_LOAD);
  assign core_reset      = (state != S_RUN);
  assign core_run        = (state == S_RUN) && run_first;
  assign busy            = (state == S_LOAD) || (state == S_BOOT) || (state == S_RUN);
  assign done            = (state == S_DONE);
  assign debug_state     = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (start_ok) next_state = S_LOAD;
      S_LOAD: if (word_accept && (host_last || ptr_at_end)) next_state = S_BOOT;
      S_BOOT: if (boot_cnt == BOOT_LAST) next_state = S_RUN;
      S_RUN:  if (halt_exit || wd_exit) next_state = S_DONE;
      S_DONE: if (start_ok) next_state = S_LOAD;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      load_ptr     <= '0;
      run_limit    <= '0;
      boot_cnt     <= '0;
      run_first    <= 1'b0;
      imem_write   <= 1'b0;
      imem_address <= '0;
      imem_data    <= '0;
      timed_out    <= 1'b0;
      exit_code    <= '0;
      last_output  <= '0;
      cycles       <= '0;
    end else begin
      imem_write <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            load_ptr    <= '0;
            run_limit   <= host_run_limit;
            timed_out   <= 1'b0;
            exit_code   <= '0;
            last_output <= '0;
            cycles      <= '0;
          end
        end
        S_LOAD: begin
          boot_cnt <= '0;
          if (word_accept) begin
            imem_write   <= 1'b1;
            imem_address <= load_ptr;
            imem_data    <= host_word;
            // Pointer stops at the top address; the load ends there instead of wrapping.
            if (!ptr_at_end) load_ptr <= load_ptr + CPU_WIDTH'(1);
          end
        end
        S_BOOT: begin
          boot_cnt  <= boot_cnt + BOOT_W'(1);
          run_first <= 1'b1;
        end
        S_RUN: begin
          run_first <= 1'b0;
          if (core_output_strobe) last_output <= core_output;
          if (halt_exit) begin
            exit_code <= core_exit_code;
            timed_out <= 1'b0;
          end else if (wd_exit) begin
            exit_code <= '1;
            timed_out <= 1'b1;
          end else if (cycles != '1) begin
            cycles <= cycles + WATCHDOG_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blocpu_run_sequencer.sv
module tb_blocpu_run_sequencer;
  localparam int CW = 8;
  localparam int IW = 12;
  localparam int WW = 16;
  localparam int BC = 2;

  // Clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          host_start;
  logic [WW-1:0] host_run_limit;
  logic [IW-1:0] host_word;
  logic          host_word_valid;
  logic          host_last;
  logic          host_word_ready;
  logic          imem_write;
  logic [CW-1:0] imem_address;
  logic [IW-1:0] imem_data;
  logic          core_reset;
  logic          core_run;
  logic          core_running;
  logic [CW-1:0] core_exit_code;
  logic [CW-1:0] core_output;
  logic          core_output_strobe;
  logic          busy;
  logic          done;
  logic          timed_out;
  logic [CW-1:0] exit_code;
  logic [CW-1:0] last_output;
  logic [WW-1:0] cycles;
  logic [2:0]    debug_state;

  blocpu_run_sequencer #(
    .CPU_WIDTH(CW), .INSTRUCTION_WIDTH(IW), .WATCHDOG_WIDTH(WW), .BOOT_CYCLES(BC)
  ) dut (
    .clock(clock), .reset(reset),
    .host_start(host_start), .host_run_limit(host_run_limit),
    .host_word(host_word), .host_word_valid(host_word_valid), .host_last(host_last),
    .host_word_ready(host_word_ready),
    .imem_write(imem_write), .imem_address(imem_address), .imem_data(imem_data),
    .core_reset(core_reset), .core_run(core_run), .core_running(core_running),
    .core_exit_code(core_exit_code), .core_output(core_output),
    .core_output_strobe(core_output_strobe),
    .busy(busy), .done(done), .timed_out(timed_out), .exit_code(exit_code),
    .last_output(last_output), .cycles(cycles), .debug_state(debug_state)
  );

  // Scoreboard
  int n_compared   = 0;
  int n_mismatched = 0;
  logic [CW+IW-1:0]   exp_q[$];  // {address, data} of each expected imem write
  logic [WW+2*CW:0]   res_q[$];  // {timed_out, exit_code, cycles, last_output}
  logic [IW-1:0]      words[$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic fail_event(input string name);
    n_compared++;
    n_mismatched++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a result.
  logic              done_q = 1'b0;
  logic [CW+IW-1:0]  mon_e;
  logic [WW+2*CW:0]  mon_r;
  always @(negedge clock) begin
    if (imem_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        fail_event("imem_unexpected_write");
      end else begin
        mon_e = exp_q.pop_front();
        check("imem_address", imem_address, mon_e[CW+IW-1:IW]);
        check("imem_data", imem_data, mon_e[IW-1:0]);
      end
    end
    if ((done === 1'b1) && !done_q) begin
      if (res_q.size() == 0) begin
        fail_event("unexpected_done");
      end else begin
        mon_r = res_q.pop_front();
        check("res_timed_out", timed_out, mon_r[WW+2*CW]);
        check("res_exit_code", exit_code, mon_r[WW+2*CW-1:WW+CW]);
        check("res_cycles", cycles, mon_r[WW+CW-1:CW]);
        check("res_last_output", last_output, mon_r[CW-1:0]);
      end
    end
    done_q = (done === 1'b1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load(input logic [WW-1:0] limit);
    host_run_limit = limit;
    host_start = 1'b1;
    step();
    host_start = 1'b0;
  endtask

  // Streams words[] with valid held high; leaves valid as-is on return.
  task automatic send_words(input logic use_last);
    for (int i = 0; i < words.size(); i++) begin
      host_word       = words[i];
      host_word_valid = 1'b1;
      host_last       = use_last && (i == words.size() - 1);
      exp_q.push_back({CW'(i), words[i]});
      step();
    end
    host_last = 1'b0;
  endtask

  // Returns at the negedge of the first RUN cycle.
  task automatic wait_core_run();
    int n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) begin
        check("ready_after_last", host_word_ready, 1'b0);
        check("boot_core_reset", core_reset, 1'b1);
      end
      if (core_run === 1'b1) begin
        n = k;
        break;
      end
    end
    check("boot_to_run_cycles", n, BC + 1);
    check("run_core_reset", core_reset, 1'b0);
  endtask

  task automatic run_core(input int halt_at, input logic [CW-1:0] code,
                          input int s1, input logic [CW-1:0] v1,
                          input int s2, input logic [CW-1:0] v2, input int start_at);
    bit finished = 0;
    for (int k = 1; k < 300; k++) begin
      step();
      core_output_strobe = 1'b0;
      host_start = 1'b0;
      if (done === 1'b1) begin
        finished = 1;
        break;
      end
      core_running   = (k != halt_at);
      core_exit_code = (k == halt_at) ? code : '0;
      if (k == s1) begin core_output_strobe = 1'b1; core_output = v1; end
      if (k == s2) begin core_output_strobe = 1'b1; core_output = v2; end
      if (k == start_at) begin host_start = 1'b1; host_run_limit = 16'd3; end
    end
    if (!finished) fail_event("run_timeout");
  endtask

  initial begin
    reset = 1'b1;
    host_start = 1'b0; host_run_limit = '0; host_word = '0;
    host_word_valid = 1'b0; host_last = 1'b0;
    core_running = 1'b1; core_exit_code = '0; core_output = '0; core_output_strobe = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge clock);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", host_word_ready, 1'b0);
    check("rst_imem_write", imem_write, 1'b0);
    check("rst_core_run", core_run, 1'b0);
    check("rst_exit_code", exit_code, 8'h00);
    check("rst_cycles", cycles, 16'h0000);
    step();
    reset = 1'b0;
    step();

    // Load 3 words, run without watchdog, core halts at RUN cycle 7 with 0x2A
    start_load(16'd0);
    words = '{12'h012, 12'h345, 12'h678};
    send_words(1'b1);
    host_word_valid = 1'b0;
    wait_core_run();
    res_q.push_back({1'b0, 8'h2A, 16'd7, 8'h00});
    run_core(7, 8'h2A, -1, 8'h00, -1, 8'h00, -1);
    @(negedge clock);
    check("done_flag", done, 1'b1);
    check("done_core_reset", core_reset, 1'b1);
    check("done_busy", busy, 1'b0);

    // Restart from DONE clears results; watchdog limit 5, core never halts
    start_load(16'd5);
    @(negedge clock);
    check("restart_exit_cleared", exit_code, 8'h00);
    check("restart_cycles_cleared", cycles, 16'h0000);
    check("restart_busy", busy, 1'b1);
    check("restart_ready", host_word_ready, 1'b1);
    words = '{12'hABC, 12'hDEF};
    send_words(1'b1);
    host_word_valid = 1'b0;
    wait_core_run();
    res_q.push_back({1'b1, 8'hFF, 16'd5, 8'h33});
    run_core(-1, 8'h00, 2, 8'h33, -1, 8'h00, -1);
    @(negedge clock);
    check("wd_core_reset", core_reset, 1'b1);

    // Halt and watchdog collide at cycles=4; strobe on the exit cycle captured
    start_load(16'd4);
    words = '{12'h9A5};
    send_words(1'b1);
    host_word_valid = 1'b0;
    wait_core_run();
    res_q.push_back({1'b0, 8'h5C, 16'd4, 8'h22});
    run_core(4, 8'h5C, 2, 8'h11, 4, 8'h22, -1);
    core_output_strobe = 1'b1;
    core_output = 8'h77;
    step();
    core_output_strobe = 1'b0;
    @(negedge clock);
    check("done_strobe_ignored", last_output, 8'h22);
    check("done_cycles_held", cycles, 16'd4);
    check("done_exit_held", exit_code, 8'h5C);

    // Full memory: 256 words, no host_last; extra word offered afterwards
    start_load(16'd0);
    words = {};
    for (int i = 0; i < 256; i++) words.push_back({4'hC, 8'(i)});
    send_words(1'b0);
    host_word = 12'hFFF;
    wait_core_run();
    host_word_valid = 1'b0;
    res_q.push_back({1'b0, 8'h07, 16'd6, 8'h00});
    run_core(6, 8'h07, -1, 8'h00, -1, 8'h00, 2);

    // Reset mid-RUN
    start_load(16'd0);
    words = '{12'h111};
    send_words(1'b1);
    host_word_valid = 1'b0;
    wait_core_run();
    core_running = 1'b1;
    step();
    core_output_strobe = 1'b1;
    core_output = 8'h44;
    step();
    core_output_strobe = 1'b0;
    step();
    @(negedge clock);
    check("prerst_cycles", cycles, 16'd3);
    check("prerst_last_output", last_output, 8'h44);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("midrun_core_reset", core_reset, 1'b1);
    check("midrun_done", done, 1'b0);
    check("midrun_busy", busy, 1'b0);
    check("midrun_cycles", cycles, 16'h0000);
    check("midrun_exit_code", exit_code, 8'h00);
    check("midrun_last_output", last_output, 8'h00);
    check("midrun_imem_write", imem_write, 1'b0);

    // Reset coinciding with a LOAD handshake: no write may follow
    start_load(16'd0);
    host_word = 12'h123;
    host_word_valid = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    host_word_valid = 1'b0;
    @(negedge clock);
    check("loadrst_imem_write", imem_write, 1'b0);
    check("loadrst_ready", host_word_ready, 1'b0);

    repeat (3) step();
    check("leftover_imem_expect", exp_q.size(), 0);
    check("leftover_result_expect", res_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
